gray_encoder_counter: RTL and testbench

Sequential binary-to-Gray encoder and Gray sequence generator; the transmit-side counterpart of the Gray decoder and LED display path. It keeps a binary count and steps it up or down on a prescaled tick, or loads it from a binary value. Each resulting code is converted to Gray and presented on a registered valid/ready output. The output feeds the Gray decoder on board and in system benches.

---
 rtl/gray_encoder_counter.sv | 153 +++++++++++++++
 tb/tb_gray_encoder_counter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_encoder_counter.sv
// Binary up/down counter with prescaled stepping, binary load, and registered Gray output on valid/ready.
// Optional Gray adjacency checker on transferred codes: GRAY_ADJ_CHECK_EN.
module gray_encoder_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] bin_in,
    output logic             load_ack,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wrap,
    output logic             overrun,
    output logic             err
);
    localparam int unsigned PCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PCW-1:0] PC_LAST = PCW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t           state, state_nx;
    logic [PCW-1:0]   pc, pc_nx;
    logic [WIDTH-1:0] bin_nx, gray_nx, step_val, flip;
    logic             valid_nx, ack_nx, wrap_nx, ovr_nx;
    logic             tick, slot_free, take_step, pending;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign tick      = en && (pc == PC_LAST);
    assign slot_free = !out_valid || out_ready;
    assign pending   = (state == STALL);
    assign pc_nx     = tick ? '0 : (en ? pc + PCW'(1) : '0);
    assign step_val  = dir ? binary + WIDTH'(1) : binary - WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and next-output decode; load outranks any step
    always_comb begin
        state_nx  = state;
        bin_nx    = binary;
        gray_nx   = gray;
        valid_nx  = out_valid && !out_ready;
        ack_nx    = 1'b0;
        wrap_nx   = (out_valid && out_ready) ? 1'b0 : wrap;
        ovr_nx    = overrun;
        take_step = 1'b0;

        if (load && slot_free) begin
            bin_nx   = bin_in;
            gray_nx  = to_gray(bin_in);
            valid_nx = 1'b1;
            ack_nx   = 1'b1;
            wrap_nx  = 1'b0;
            state_nx = en ? RUN : IDLE;
        end else begin
            if (load) ovr_nx = 1'b1;
            case (state)
                IDLE, RUN: begin
                    if (!en) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = RUN;
                        if (tick) begin
                            if (slot_free) take_step = 1'b1;
                            else           state_nx  = STALL;
                        end
                    end
                end
                STALL: begin
                    if (!en) begin
                        state_nx = IDLE;
                    end else begin
                        if (tick && pending) ovr_nx = 1'b1;
                        if (slot_free) begin
                            take_step = 1'b1;
                            state_nx  = RUN;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase

            if (take_step) begin
                bin_nx   = step_val;
                gray_nx  = to_gray(step_val) ^ flip;
                valid_nx = 1'b1;
                wrap_nx  = dir ? (binary == '1) : (binary == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            binary    <= '0;
            gray      <= '0;
            out_valid <= 1'b0;
            load_ack  <= 1'b0;
            wrap      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            pc        <= pc_nx;
            binary    <= bin_nx;
            gray      <= gray_nx;
            out_valid <= valid_nx;
            load_ack  <= ack_nx;
            wrap      <= wrap_nx;
            overrun   <= ovr_nx;
        end
    end

`ifdef GRAY_ADJ_CHECK_EN
    logic [WIDTH-1:0] prev_gray;
    logic             prev_ok, loaded, err_q;

    // Fault-injection hook on stepped codes; tied off in the design
    assign flip = '0;

    // Stepped codes must differ from the last transferred code in exactly one bit
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray <= '0;
            prev_ok   <= 1'b0;
            loaded    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (prev_ok && !loaded && ($countones(gray ^ prev_gray) != 1)) err_q <= 1'b1;
                prev_gray <= gray;
                prev_ok   <= 1'b1;
            end
            if (ack_nx)         loaded <= 1'b1;
            else if (take_step) loaded <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign flip = '0;
    assign err  = 1'b0;
`endif
endmodule

// File: tb/tb_gray_encoder_counter.sv
// Bench for gray_encoder_counter: DIV=1 and DIV=3 instances on shared stimulus, vector table,
// hand sequences, and randomized traffic against an integer reference model.
module tb_gray_encoder_counter;
    localparam int unsigned W   = 4;
    localparam int unsigned MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst, en, dir, load, out_ready;
    logic [W-1:0] bin_in;
    logic [W-1:0] g1, b1, g3, b3;
    logic         a1, v1, w1, o1, e1, a3, v3, w3, o3, e3;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_on = 1'b1;

    always #5 clk = ~clk;

    gray_encoder_counter #(.WIDTH(W), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .bin_in(bin_in),
        .load_ack(a1), .gray(g1), .binary(b1), .out_valid(v1), .out_ready(out_ready),
        .wrap(w1), .overrun(o1), .err(e1));

    gray_encoder_counter #(.WIDTH(W), .DIV(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .bin_in(bin_in),
        .load_ack(a3), .gray(g3), .binary(b3), .out_valid(v3), .out_ready(out_ready),
        .wrap(w3), .overrun(o3), .err(e3));

    typedef struct {
        int unsigned bin;
        int unsigned pc;
        bit valid, ack, wrap, ovr, pend;
    } mdl_t;

    mdl_t m1, m3;

    function automatic int unsigned gray_of(input int unsigned b);
        return b ^ (b >> 1);
    endfunction

    // Reference behaviour from the block's rules, one clock edge at a time
    function automatic mdl_t mdl_next(input mdl_t m, input int unsigned div, input bit r, input bit e,
                                      input bit d, input bit ld, input int unsigned bi, input bit rdy);
        mdl_t n;
        bit   free, tk, stp;
        n   = m;
        stp = 1'b0;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        free  = !m.valid || rdy;
        tk    = e && (m.pc == div - 1);
        n.pc  = (!e || tk) ? 0 : m.pc + 1;
        n.ack = 1'b0;
        if (m.valid && rdy) begin
            n.valid = 1'b0;
            n.wrap  = 1'b0;
        end
        if (ld && free) begin
            n.bin   = bi;
            n.valid = 1'b1;
            n.ack   = 1'b1;
            n.wrap  = 1'b0;
            n.pend  = 1'b0;
        end else begin
            if (ld) n.ovr = 1'b1;
            if (!e) begin
                n.pend = 1'b0;
            end else if (m.pend) begin
                if (tk) n.ovr = 1'b1;
                if (free) begin
                    stp    = 1'b1;
                    n.pend = 1'b0;
                end
            end else if (tk) begin
                if (free) stp = 1'b1;
                else      n.pend = 1'b1;
            end
            if (stp) begin
                n.bin   = d ? (m.bin + 1) % MOD : (m.bin + MOD - 1) % MOD;
                n.wrap  = d ? (m.bin == MOD - 1) : (m.bin == 0);
                n.valid = 1'b1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string who, input mdl_t m, input logic [W-1:0] g, input logic [W-1:0] b,
                             input logic v, input logic a, input logic w, input logic o, input logic e);
        chk({who, " gray"}, g, gray_of(m.bin));
        chk({who, " binary"}, b, m.bin);
        chk({who, " out_valid"}, v, m.valid);
        chk({who, " load_ack"}, a, m.ack);
        chk({who, " wrap"}, w, m.wrap);
        chk({who, " overrun"}, o, m.ovr);
        chk({who, " err"}, e, 0);
    endtask

    task automatic drive(input bit r, input bit e, input bit d, input bit l, input logic [W-1:0] bi, input bit rdy);
        rst = r; en = e; dir = d; load = l; bin_in = bi; out_ready = rdy;
    endtask

    // One clock edge: advance both models, then compare both instances 1 time unit later
    task automatic step();
        @(posedge clk);
        m1 = mdl_next(m1, 1, rst, en, dir, load, bin_in, out_ready);
        m3 = mdl_next(m3, 3, rst, en, dir, load, bin_in, out_ready);
        #1;
        if (model_on) begin
            cmp_model("div1", m1, g1, b1, v1, a1, w1, o1, e1);
            cmp_model("div3", m3, g3, b3, v3, a3, w3, o3, e3);
        end
    endtask

    typedef struct {
        bit         r, e, d, l;
        logic [3:0] bi;
        bit         rdy;
        logic [3:0] g, b;
        bit         v, a, w, o;
    } vec_t;

    vec_t tv[9];
    logic [3:0] up_seq[16];

    initial begin
        m1 = '{default: 0};
        m3 = '{default: 0};
        drive(1, 0, 0, 0, 4'h0, 0);

        //         r  e  d  l  bin    rdy  gray   bin    v  a  w  o
        tv[0] = '{1, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 0};
        tv[1] = '{0, 0, 0, 1, 4'hB, 0, 4'hE, 4'hB, 1, 1, 0, 0};
        tv[2] = '{0, 0, 0, 0, 4'h0, 1, 4'hE, 4'hB, 0, 0, 0, 0};
        tv[3] = '{0, 1, 1, 0, 4'h0, 1, 4'hA, 4'hC, 1, 0, 0, 0};
        tv[4] = '{0, 1, 1, 0, 4'h0, 0, 4'hA, 4'hC, 1, 0, 0, 0};
        tv[5] = '{0, 1, 1, 0, 4'h0, 0, 4'hA, 4'hC, 1, 0, 0, 1};
        tv[6] = '{0, 1, 1, 0, 4'h0, 1, 4'hB, 4'hD, 1, 0, 0, 1};
        tv[7] = '{0, 0, 0, 1, 4'h0, 0, 4'hB, 4'hD, 1, 0, 0, 1};
        tv[8] = '{1, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 0};

        up_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                   4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            drive(tv[i].r, tv[i].e, tv[i].d, tv[i].l, tv[i].bi, tv[i].rdy);
            step();
            chk($sformatf("vec%0d gray", i), g1, tv[i].g);
            chk($sformatf("vec%0d binary", i), b1, tv[i].b);
            chk($sformatf("vec%0d out_valid", i), v1, tv[i].v);
            chk($sformatf("vec%0d load_ack", i), a1, tv[i].a);
            chk($sformatf("vec%0d wrap", i), w1, tv[i].w);
            chk($sformatf("vec%0d overrun", i), o1, tv[i].o);
        end

        // Full up count at DIV=1 with the consumer always ready
        drive(0, 1, 1, 0, 4'h0, 1);
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("up%0d gray", i), g1, up_seq[i]);
            chk($sformatf("up%0d wrap", i), w1, (i == 15) ? 1 : 0);
            chk($sformatf("up%0d out_valid", i), v1, 1);
            chk($sformatf("up%0d err", i), e1, 0);
        end

        // DIV=3 counting down from zero
        drive(1, 0, 0, 0, 4'h0, 1);
        step();
        drive(0, 1, 0, 0, 4'h0, 1);
        step();
        chk("div3 idle1 out_valid", v3, 0);
        step();
        chk("div3 idle2 out_valid", v3, 0);
        step();
        chk("div3 first binary", b3, 4'hF);
        chk("div3 first gray", g3, 4'h8);
        chk("div3 first wrap", w3, 1);
        chk("div3 first out_valid", v3, 1);
        step();
        chk("div3 gap out_valid", v3, 0);
        chk("div3 gap wrap", w3, 0);
        step();
        step();
        chk("div3 second binary", b3, 4'hE);
        chk("div3 second gray", g3, 4'h9);
        chk("div3 second wrap", w3, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, 1'($urandom),
                  $urandom_range(0, 15) == 0, 4'($urandom), $urandom_range(0, 3) != 0);
            step();
        end

`ifdef GRAY_ADJ_CHECK_EN
        // Corrupt one stepped code by two bits and confirm the sticky error
        model_on = 1'b0;
        drive(1, 0, 0, 0, 4'h0, 1);
        step();
        drive(0, 1, 1, 0, 4'h0, 1);
        step();
        step();
        step();
        chk("adj clean err", e1, 0);
        force dut1.flip = 4'b1001;
        step();
        release dut1.flip;
        chk("adj corrupt gray", g1, 4'hF);
        chk("adj before transfer err", e1, 0);
        step();
        chk("adj after transfer err", e1, 1);
        drive(0, 0, 0, 0, 4'h0, 1);
        step();
        step();
        chk("adj sticky err", e1, 1);
        drive(1, 0, 0, 0, 4'h0, 1);
        step();
        chk("adj reset err", e1, 0);
        model_on = 1'b1;
        drive(0, 0, 0, 0, 4'h0, 1);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
